// File: rtl/parser_pkg.sv
// Shared types and constants for the parser pipeline.
// Covers the rule-configuration controller FSM, its request record and its special values.
package parser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        RESP
    } rule_ctrl_state_e;

    localparam logic [7:0]  RULE_LAYER_BCAST     = 8'hFF;
    localparam logic [31:0] RULE_RD_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  sel;
    } rule_req_t;

endpackage

// File: rtl/rule_rdata_mux.sv
// Selects one layer's rule read data and valid by layer select.
// Out-of-range selects yield zero data and no valid.
module rule_rdata_mux #(
    parameter int LAYER_NUM = 4
) (
    input  logic [7:0]             sel,
    input  logic [LAYER_NUM*32-1:0] rule_rdata,
    input  logic [LAYER_NUM-1:0]   rule_rdata_valid,
    output logic [31:0]            rdata,
    output logic                   rdata_valid
);

    always_comb begin
        rdata       = '0;
        rdata_valid = 1'b0;
        for (int i = 0; i < LAYER_NUM; i++) begin
            if (sel == 8'(i)) begin
                rdata       = rule_rdata[i*32 +: 32];
                rdata_valid = rule_rdata_valid[i];
            end
        end
    end

endmodule

// File: rtl/parser_rule_ctrl.sv
// Host-side rule-configuration controller: one outstanding read/write per time,
// decoded to per-layer strobes, with error and read-timeout responses.
module parser_rule_ctrl
    import parser_pkg::*;
#(
    parameter int LAYER_NUM     = 4,
    parameter int LAYER_SEL_LSB = 24,
    parameter int RD_TIMEOUT    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_write,
    input  logic [31:0]             i_req_addr,
    input  logic [31:0]             i_req_wdata,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [31:0]             o_resp_rdata,
    output logic                    o_resp_err,
    output logic [LAYER_NUM-1:0]    o_rule_wren,
    output logic [LAYER_NUM-1:0]    o_rule_rden,
    output logic [31:0]             o_rule_addr,
    output logic [31:0]             o_rule_wdata,
    input  logic [LAYER_NUM-1:0]    i_rule_rdata_valid,
    input  logic [LAYER_NUM*32-1:0] i_rule_rdata,
    output logic [15:0]             o_err_cnt
);

    localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [31:0]          SEL_MASK = 32'hFF << LAYER_SEL_LSB;
    localparam logic [LAYER_NUM-1:0] ONE_HOT0 = LAYER_NUM'(1);

    rule_ctrl_state_e     state_q, state_d;
    rule_req_t            req_q, req_d;
    logic [LAYER_NUM-1:0] wren_q, wren_d, rden_q, rden_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [15:0]          err_cnt_q, err_cnt_d;

    logic [7:0]  in_sel;
    logic        in_sel_ok, sel_ok, sel_bcast;
    logic [31:0] mux_rdata;
    logic        mux_valid;

    assign in_sel    = i_req_addr[LAYER_SEL_LSB +: 8];
    assign in_sel_ok = {24'd0, in_sel} < 32'(LAYER_NUM);
    assign sel_ok    = {24'd0, req_q.sel} < 32'(LAYER_NUM);
    assign sel_bcast = req_q.sel == RULE_LAYER_BCAST;

    rule_rdata_mux #(.LAYER_NUM(LAYER_NUM)) u_rdata_mux (
        .sel              (req_q.sel),
        .rule_rdata       (i_rule_rdata),
        .rule_rdata_valid (i_rule_rdata_valid),
        .rdata            (mux_rdata),
        .rdata_valid      (mux_valid)
    );

    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of block order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            wren_q    <= '0;
            rden_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            wren_q    <= wren_d;
            rden_q    <= rden_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wren_d    = '0;
        rden_d    = '0;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    req_d   = '{write: i_req_write, addr: i_req_addr, wdata: i_req_wdata, sel: in_sel};
                    state_d = ISSUE;
                    // Strobes are registered here so they appear exactly in the ISSUE cycle.
                    if (in_sel_ok && i_req_write)        wren_d = ONE_HOT0 << in_sel;
                    else if (in_sel_ok)                  rden_d = ONE_HOT0 << in_sel;
                    else if (in_sel == RULE_LAYER_BCAST && i_req_write) wren_d = '1;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = RESP;
                if (req_q.write)     err_d   = !(sel_ok || sel_bcast);
                else if (!sel_ok)    err_d   = 1'b1;
                else if (mux_valid)  rdata_d = mux_rdata;
                else                 state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mux_valid) begin
                    rdata_d = mux_rdata;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = RULE_RD_TIMEOUT_DATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != RESP && state_d == RESP && err_d && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_comb begin
        o_req_ready  = state_q == IDLE;
        o_resp_valid = state_q == RESP;
    end

    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;
    assign o_rule_wren  = wren_q;
    assign o_rule_rden  = rden_q;
    assign o_rule_addr  = req_q.addr & ~SEL_MASK;
    assign o_rule_wdata = req_q.wdata;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: doc/parser_rule_ctrl.md
# parser_rule_ctrl

Host-side rule-configuration controller for the parser pipeline. It accepts single-word read/write requests from one host port over a valid/ready handshake and decodes the target layer from the address. It drives the per-layer rule-write/read strobes of the `LAYER_NUM` parser layers, then returns exactly one response per request, including error and read-timeout handling. Only one transaction is outstanding at a time.

## Interface
- `LAYER_NUM`, 4: number of parser layers served (1..254).
- `LAYER_SEL_LSB`, 24: LSB of the 8-bit layer-select field `i_req_addr[LAYER_SEL_LSB+7:LAYER_SEL_LSB]`.
- `RD_TIMEOUT`, 16: cycles to wait for read data after the read strobe (≥1).
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_req_valid`  in  1  host request valid
- `o_req_ready`  out  1  controller can accept a request
- `i_req_write`  in  1  1 = write, 0 = read
- `i_req_addr`  in  32  layer select plus rule address
- `i_req_wdata`  in  32  write data
- `o_resp_valid`  out  1  response valid
- `i_resp_ready`  in  1  host takes the response
- `o_resp_rdata`  out  32  read data; 0 for writes
- `o_resp_err`  out  1  1 = bad layer, broadcast read, or timeout
- `o_rule_wren`  out  LAYER_NUM  per-layer write strobe
- `o_rule_rden`  out  LAYER_NUM  per-layer read strobe
- `o_rule_addr`  out  32  shared; the request address with the layer field zeroed
- `o_rule_wdata`  out  32  shared write data
- `i_rule_rdata_valid`  in  LAYER_NUM  per-layer read data valid
- `i_rule_rdata`  in  LAYER_NUM×32  per-layer read data
- `o_err_cnt`  out  16  saturating count of error responses

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE:
  - `o_req_ready`=1.
  - On `i_req_valid && o_req_ready`, register write flag, address, data and layer select `sel`, then go to ISSUE.
- ISSUE (one cycle), with registered strobes:
  - Valid write (`sel` < LAYER_NUM): `o_rule_wren[sel]`=1, then go to RESP with err=0 and rdata=0.
  - Broadcast write (`sel`=8'hFF): all `o_rule_wren` bits = 1, then go to RESP with err=0.
  - Valid read: `o_rule_rden[sel]`=1.
    - If `i_rule_rdata_valid[sel]` is high in this cycle, capture `i_rule_rdata[sel]` and go to RESP.
    - Otherwise go to RD_WAIT.
  - Invalid select, or broadcast read: no strobe; go to RESP with err=1 and rdata=0.
- RD_WAIT:
  - Strobes are 0; the read strobe is never repeated.
  - Timeout counter increments each cycle.
  - First `i_rule_rdata_valid[sel]` captures the data and goes to RESP.
  - When the counter reaches RD_TIMEOUT: go to RESP with err=1 and rdata=32'hDEAD_BEEF.
- RESP:
  - `o_resp_valid`=1; data and err are held stable.
  - On `i_resp_ready`, return to IDLE.
- `o_rule_addr` and `o_rule_wdata` are driven from the request registers and held from ISSUE until the next acceptance.
- Read-valid from a non-selected layer, or any read-valid outside ISSUE/RD_WAIT, is ignored.
- `o_err_cnt` increments on each error response; it saturates at 16'hFFFF.

## Timing
- Reset values: every output is 0, except `o_req_ready`=1. State = IDLE, counters = 0.
- Write accepted at cycle T: `o_rule_wren` high at T+1 only, `o_resp_valid` from T+2.
- Read with same-cycle valid: rden at T+1, response at T+2.
- Read answered k cycles after rden: response at T+2+k (k ≤ RD_TIMEOUT).
- Read timeout: response at T+2+RD_TIMEOUT.
- Error request: no strobe; response at T+2.
- `o_req_ready` is 0 from T+1 until the cycle after the response handshake. A new request is accepted at the earliest one cycle after `o_resp_valid && i_resp_ready`.
- Response back-pressure holds RESP indefinitely; no strobes occur meanwhile.
- Reset asserted mid-transaction: the pending transaction is dropped with no response, and strobes drop immediately.

## Structure
- Add to `parser_pkg`:
  - `rule_ctrl_state_e` (IDLE/ISSUE/RD_WAIT/RESP)
  - `RULE_LAYER_BCAST`=8'hFF
  - `RULE_RD_TIMEOUT_DATA`=32'hDEAD_BEEF
  - `rule_req_t` (write flag, addr, wdata, sel).
- One sub-module, `rule_rdata_mux`: combinational select of `i_rule_rdata` and `i_rule_rdata_valid` by `sel`.

## Test plan
- Write to layer 2 (addr 32'h0200_0010, data 32'h1234_5678), `i_resp_ready`=1:
  - `o_rule_wren`=4'b0100 for one cycle, `o_rule_addr`=32'h0000_0010.
  - Response at T+2 with err=0, rdata=0.
- Read from layer 1, model returns valid in the same cycle as rden with 32'hCAFE_0001:
  - `o_rule_rden`=4'b0010 for one cycle.
  - Response at T+2 with rdata=32'hCAFE_0001, err=0.
- Read from layer 3, model answers 5 cycles late with 32'hA5A5_A5A5; layer 0 pulses a spurious valid meanwhile:
  - Response at T+7 with rdata=32'hA5A5_A5A5.
  - Spurious valid ignored.
- Read with no answer, RD_TIMEOUT=16:
  - Response at T+18 with err=1, rdata=32'hDEAD_BEEF.
  - `o_err_cnt`=1.
- Requests with select 8'h07, a broadcast read, and a broadcast write:
  - 8'h07 and broadcast read: no strobes, err=1.
  - Broadcast write: `o_rule_wren`=4'b1111, err=0.
  - `o_err_cnt` += 2.
- Edge cases:
  - Hold `i_resp_ready`=0 for 10 cycles: `o_resp_valid` and data stay stable, `o_req_ready` stays 0.
  - Assert reset during RD_WAIT: no response is produced, outputs return to reset values, and the next request completes normally.
